// File: rtl/lfp_mult_rr_arbiter.sv
// Round-robin arbiter sharing one E3M4 log-domain multiplier among NREQ lanes,
// with results tagged by lane id and queued in a 2-entry in-order FIFO.

module lfp_mult_e3m4_fig3 (
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  output logic [8:0] y
);

  logic       v1;
  logic       v2;
  logic       vo;
  logic [7:0] ya;
  logic [3:0] man;

  // v is the log-domain correction bit: clear for mantissas 000x and 1111
  always_comb begin
    v1  = !((x1[3:1] == 3'b000) || (x1[3:0] == 4'hF));
    v2  = !((x2[3:1] == 3'b000) || (x2[3:0] == 4'hF));
    ya  = {1'b0, x1[6:0]} + {1'b0, x2[6:0]} + {7'd0, v1} + {7'd0, v2};
    vo  = !((ya[3:1] == 3'b000) || (ya[3:0] == 4'hF));
    man = ya[3:0] - {3'd0, vo};
    if ((x1[6:4] == 3'd0) || (x2[6:4] == 3'd0)) begin
      y = 9'h000;
    end else begin
      y = {x1[7] ^ x2[7], ya[7:4], man};
    end
  end

endmodule

module lfp_mult_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_x1,
  input  logic [8*NREQ-1:0] req_x2,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [8:0]        rsp_y,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] k_sel;
  logic [IDW-1:0] ptr_next;
  logic [IDW:0]   sum;
  logic [IDW:0]   nxt;
  logic [NREQ-1:0] rot;
  logic [7:0]     sel_x1;
  logic [7:0]     sel_x2;
  logic [8:0]     prod;
  logic [8:0]     tail_y;
  logic [IDW-1:0] tail_id;
  logic           any_valid;
  logic           can_accept;
  logic           push;
  logic           pop;

  // Rotating the valids by ptr turns the wrap-around search into a plain priority encode
  assign rot = NREQ'({req_valid, req_valid} >> ptr);

  always_comb begin
    k_sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) k_sel = IDW'(k);
    end
    sum      = {1'b0, ptr} + {1'b0, k_sel};
    cand     = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : IDW'(sum);
    nxt      = {1'b0, cand} + (IDW+1)'(1);
    ptr_next = (nxt == NREQ_W) ? '0 : IDW'(nxt);
    sel_x1   = '0;
    sel_x2   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (cand == IDW'(k)) begin
        sel_x1 = req_x1[8*k +: 8];
        sel_x2 = req_x2[8*k +: 8];
      end
    end
  end

  lfp_mult_e3m4_fig3 u_mult (
    .x1 (sel_x1),
    .x2 (sel_x2),
    .y  (prod)
  );

  assign any_valid  = |req_valid;
  assign rsp_valid  = (state != EMPTY);
  assign can_accept = (state != FULL) || rsp_ready;
  assign push       = !rst && any_valid && can_accept;
  assign pop        = rsp_valid && rsp_ready;
  assign req_ready  = push ? (NREQ'(1) << cand) : '0;

  // rsp_y/rsp_id are the head slot; the tail slot only holds data in FULL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ptr     <= '0;
      rsp_y   <= '0;
      rsp_id  <= '0;
      tail_y  <= '0;
      tail_id <= '0;
    end else begin
      if (push) ptr <= ptr_next;
      case (state)
        EMPTY: begin
          if (push) begin
            rsp_y  <= prod;
            rsp_id <= cand;
            state  <= HALF;
          end
        end
        HALF: begin
          if (push && pop) begin
            rsp_y  <= prod;
            rsp_id <= cand;
          end else if (push) begin
            tail_y  <= prod;
            tail_id <= cand;
            state   <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            rsp_y  <= tail_y;
            rsp_id <= tail_id;
            if (push) begin
              tail_y  <= prod;
              tail_id <= cand;
            end else begin
              state <= HALF;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_lfp_mult_rr_arbiter.sv
// Randomized and directed bench for lfp_mult_rr_arbiter against a queue-based
// reference model of the arbiter, FIFO and log-domain product.

module tb_lfp_mult_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_x1;
  logic [8*NREQ-1:0] req_x2;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [8:0]        rsp_y;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;

  int checks   = 0;
  int failures = 0;

  int             m_ptr;
  logic [8:0]     q_y[$];
  logic [IDW-1:0] q_id[$];

  always #5 clk = ~clk;

  lfp_mult_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  function automatic int vbit(int m);
    return ((m < 2) || (m == 15)) ? 0 : 1;
  endfunction

  function automatic logic [8:0] ref_mult(logic [7:0] a, logic [7:0] b);
    int ya, ym, s;
    if ((a[6:4] == 3'd0) || (b[6:4] == 3'd0)) return 9'h000;
    ya = (int'(a[6:0]) + int'(b[6:0]) + vbit(int'(a[3:0])) + vbit(int'(b[3:0]))) % 256;
    ym = ya % 16;
    s  = int'(a[7] ^ b[7]);
    return 9'(s * 256 + (ya / 16) * 16 + (ym - vbit(ym)));
  endfunction

  function automatic int model_cand();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int c;
    c = model_cand();
    if ((c < 0) || !((q_y.size() < 2) || rsp_ready)) return '0;
    return NREQ'(1) << c;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven
  task automatic model_edge(output int g);
    int c;
    c = model_cand();
    g = -1;
    if ((c >= 0) && ((q_y.size() < 2) || rsp_ready)) g = c;
    if ((q_y.size() > 0) && rsp_ready) begin
      void'(q_y.pop_front());
      void'(q_id.pop_front());
    end
    if (g >= 0) begin
      q_y.push_back(ref_mult(req_x1[8*g +: 8], req_x2[8*g +: 8]));
      q_id.push_back(IDW'(g));
      m_ptr = (g + 1) % NREQ;
    end
  endtask

  task automatic model_clear();
    q_y.delete();
    q_id.delete();
    m_ptr = 0;
  endtask

  task automatic new_ops(input int lane);
    req_x1[8*lane +: 8] = 8'($urandom);
    req_x2[8*lane +: 8] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_x1    = '0;
    req_x2    = '0;
    #1;
    checks++; if (req_ready !== '0) begin failures++; $display("[TB] FAIL reset_ready got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_y !== 9'h000) begin failures++; $display("[TB] FAIL reset_y got %h want 000", rsp_y); end
    checks++; if (rsp_id !== '0) begin failures++; $display("[TB] FAIL reset_id got %0d want 0", rsp_id); end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    model_clear();
  endtask

  task automatic test_single_products();
    logic [7:0] a_tbl[4] = '{8'h38, 8'hB8, 8'h05, 8'h10};
    logic [7:0] b_tbl[4] = '{8'h38, 8'h38, 8'h38, 8'h10};
    logic [8:0] y_tbl[4] = '{9'h071, 9'h171, 9'h000, 9'h020};
    int g;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = NREQ'(1) << i;
      req_x1[8*i +: 8] = a_tbl[i];
      req_x2[8*i +: 8] = b_tbl[i];
      #1;
      checks++; if (req_ready !== (NREQ'(1) << i)) begin failures++; $display("[TB] FAIL single_ready lane %0d got %b want %b", i, req_ready, NREQ'(1) << i); end
      model_edge(g);
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid lane %0d got %b want 1", i, rsp_valid); end
      checks++; if (rsp_y !== y_tbl[i]) begin failures++; $display("[TB] FAIL single_y lane %0d got %h want %h", i, rsp_y, y_tbl[i]); end
      checks++; if (rsp_id !== IDW'(i)) begin failures++; $display("[TB] FAIL single_id got %0d want %0d", rsp_id, i); end
      model_edge(g);
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int cnt[NREQ];
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0;
      new_ops(i);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      checks++; if (req_ready !== (NREQ'(1) << (n % NREQ))) begin failures++; $display("[TB] FAIL rr_order cycle %0d got %b want %b", n, req_ready, NREQ'(1) << (n % NREQ)); end
      checks++; if (rsp_valid !== (q_y.size() > 0)) begin failures++; $display("[TB] FAIL rr_valid cycle %0d got %b want %0d", n, rsp_valid, q_y.size() > 0); end
      if (q_y.size() > 0) begin
        checks++; if ((rsp_y !== q_y[0]) || (rsp_id !== q_id[0])) begin failures++; $display("[TB] FAIL rr_head cycle %0d got %0d/%h want %0d/%h", n, rsp_id, rsp_y, q_id[0], q_y[0]); end
      end
      for (int i = 0; i < NREQ; i++) cnt[i] += int'(req_ready[i]);
      model_edge(g);
      @(negedge clk);
      if (g >= 0) new_ops(g);
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++; if (cnt[i] != 25) begin failures++; $display("[TB] FAIL rr_share lane %0d got %0d want 25", i, cnt[i]); end
    end
    req_valid = '0;
    #1;
    checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== q_id[0]) || (rsp_y !== q_y[0])) begin failures++; $display("[TB] FAIL rr_last got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_y, q_id[0], q_y[0]); end
    model_edge(g);
    @(negedge clk);
  endtask

  task automatic test_wrap_skip();
    int g;
    int order[4] = '{1, 3, 1, 3};
    req_valid = 4'b1010;
    new_ops(1);
    new_ops(3);
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (req_ready !== (NREQ'(1) << order[n])) begin failures++; $display("[TB] FAIL wrap_order step %0d got %b want %b", n, req_ready, NREQ'(1) << order[n]); end
      if (q_y.size() > 0) begin
        checks++; if ((rsp_y !== q_y[0]) || (rsp_id !== q_id[0])) begin failures++; $display("[TB] FAIL wrap_head step %0d got %0d/%h want %0d/%h", n, rsp_id, rsp_y, q_id[0], q_y[0]); end
      end
      model_edge(g);
      @(negedge clk);
      if (g >= 0) new_ops(g);
    end
    req_valid = '0;
    #1;
    checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== IDW'(3))) begin failures++; $display("[TB] FAIL wrap_last got %b/%0d want 1/3", rsp_valid, rsp_id); end
    model_edge(g);
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    int g;
    logic [NREQ-1:0] rdy_tbl[5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
    logic            pop_tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      rsp_ready = pop_tbl[n];
      #1;
      checks++; if (req_ready !== rdy_tbl[n]) begin failures++; $display("[TB] FAIL bp_ready step %0d got %b want %b", n, req_ready, rdy_tbl[n]); end
      if (n >= 2) begin
        checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== IDW'((n == 4) ? 1 : 0))) begin failures++; $display("[TB] FAIL bp_head step %0d got %b/%0d want 1/%0d", n, rsp_valid, rsp_id, (n == 4) ? 1 : 0); end
        checks++; if (rsp_y !== q_y[0]) begin failures++; $display("[TB] FAIL bp_y step %0d got %h want %h", n, rsp_y, q_y[0]); end
      end
      model_edge(g);
      @(negedge clk);
      if (g >= 0) new_ops(g);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (rsp_valid !== (q_y.size() > 0)) begin failures++; $display("[TB] FAIL bp_drain_valid step %0d got %b want %0d", n, rsp_valid, q_y.size() > 0); end
      if (q_y.size() > 0) begin
        checks++; if ((rsp_y !== q_y[0]) || (rsp_id !== q_id[0])) begin failures++; $display("[TB] FAIL bp_drain step %0d got %0d/%h want %0d/%h", n, rsp_id, rsp_y, q_id[0], q_y[0]); end
      end
      model_edge(g);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    logic [8:0] exp_y;
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (req_ready !== model_ready()) begin failures++; $display("[TB] FAIL rmid_fill step %0d got %b want %b", n, req_ready, model_ready()); end
      model_edge(g);
      @(negedge clk);
      if (g >= 0) new_ops(g);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_valid got %b want 0", rsp_valid); end
    checks++; if (req_ready !== '0) begin failures++; $display("[TB] FAIL rmid_ready got %b want 0", req_ready); end
    model_clear();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    new_ops(2);
    exp_y = ref_mult(req_x1[23:16], req_x2[23:16]);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_post_valid got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL rmid_grant got %b want 0100", req_ready); end
    model_edge(g);
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== IDW'(2)) || (rsp_y !== exp_y)) begin failures++; $display("[TB] FAIL rmid_rsp got %b/%0d/%h want 1/2/%h", rsp_valid, rsp_id, rsp_y, exp_y); end
    model_edge(g);
    @(negedge clk);
  endtask

  task automatic test_random();
    int g;
    logic [NREQ-1:0] exp_r;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req_valid = NREQ'($urandom);
    for (int n = 0; n < 400; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_r = model_ready();
      checks++; if (req_ready !== exp_r) begin failures++; $display("[TB] FAIL rand_ready cycle %0d got %b want %b", n, req_ready, exp_r); end
      checks++; if (rsp_valid !== (q_y.size() > 0)) begin failures++; $display("[TB] FAIL rand_valid cycle %0d got %b want %0d", n, rsp_valid, q_y.size() > 0); end
      if (q_y.size() > 0) begin
        checks++; if ((rsp_y !== q_y[0]) || (rsp_id !== q_id[0])) begin failures++; $display("[TB] FAIL rand_head cycle %0d got %0d/%h want %0d/%h", n, rsp_id, rsp_y, q_id[0], q_y[0]); end
      end
      model_edge(g);
      @(negedge clk);
      if (g >= 0) begin
        new_ops(g);
        req_valid[g] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          new_ops(i);
          req_valid[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_products();
    test_round_robin();
    test_wrap_skip();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
